// File: rtl/wb_decoder_pkg.sv
// rtl/wb_decoder_pkg.sv - shared types and default address map for the Wishbone decoder
// Holds the slave-select and outstanding-count types, the UNMAPPED
// select code and the default slave address map (RAM, LED, UART, timer).
package wb_decoder_pkg;

  localparam int unsigned NSLV_DEF      = 4;
  localparam int unsigned MAX_OUTST_DEF = 4;
  localparam int unsigned TIMEOUT_DEF   = 1024;

  // One code per slave plus one extra code for "no slave matched".
  typedef logic [$clog2(NSLV_DEF+1)-1:0]      sel_t;
  typedef logic [$clog2(MAX_OUTST_DEF+1)-1:0] outst_t;

  localparam sel_t UNMAPPED = sel_t'(NSLV_DEF);

  localparam logic [31:0] BASE_DEF [NSLV_DEF] =
    '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
  localparam logic [31:0] MASK_DEF [NSLV_DEF] =
    '{32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

endpackage

// File: rtl/wb_decoder_if.sv
// rtl/wb_decoder_if.sv - pipelined Wishbone bus interface with master/slave modports
// Ports: clk (bus clock). Signals: cyc/stb/we/adr/sel/dat_i flow master to
// slave; dat_o/ack/err/stall flow slave to master.
interface wb_if
  import wb_decoder_pkg::*;
(
  input logic clk
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (input clk, output cyc, stb, we, adr, sel, dat_i,
                  input dat_o, ack, err, stall);
  modport slave  (input clk, input cyc, stb, we, adr, sel, dat_i,
                  output dat_o, ack, err, stall);
endinterface

// File: rtl/wb_decoder_tmo.sv
// rtl/wb_decoder_tmo.sv - response timeout counter for the Wishbone decoder
// Ports: clk, rst (async, active-high); clr restarts the count; en lets it
// advance; fire pulses for one cycle when TIMEOUT cycles have elapsed.
module wb_decoder_tmo
  import wb_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic fire
);
  localparam int unsigned W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt;

  // A response in the firing cycle wins: the request was answered in time.
  assign fire = en & ~clr & (cnt == W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr | fire) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end
endmodule

// File: rtl/wb_decoder.sv
// rtl/wb_decoder.sv - pipelined Wishbone 1-to-NSLV address decoder with error and timeout handling
// Ports: clk, rst (async, active-high); m = upstream slave port facing the
// CPU data bus; s[NSLV] = downstream master ports, one per peripheral.
module wb_decoder
  import wb_decoder_pkg::*;
#(
  parameter int unsigned NSLV              = NSLV_DEF,
  parameter logic [31:0] BASE [NSLV]      = BASE_DEF,
  parameter logic [31:0] MASK [NSLV]      = MASK_DEF,
  parameter int unsigned MAX_OUTST         = MAX_OUTST_DEF,
  parameter int unsigned TIMEOUT           = TIMEOUT_DEF
) (
  input logic  clk,
  input logic  rst,
  wb_if.slave  m,
  wb_if.master s [NSLV]
);
  sel_t   dec;
  sel_t   sel_q;
  outst_t outst;
  logic   uerr_q;
  logic   drain;

  logic [NSLV-1:0] s_ack, s_err, s_stall, s_cyc, s_stb;
  logic [31:0]     s_rdat [NSLV];

  logic        busy, dec_stall, slv_stall, accept;
  logic        rsp_ack, rsp_err, rsp, tmo_en, tmo_fire;
  logic [31:0] rsp_dat;

  // Lowest matching index wins, so scan downwards and let lower hits overwrite.
  always_comb begin
    dec = UNMAPPED;
    for (int i = int'(NSLV) - 1; i >= 0; i--) begin
      if ((m.adr & MASK[i]) == BASE[i]) dec = sel_t'(i);
    end
  end

  assign busy      = (outst != '0);
  // Responses must come back in order, so a different target waits until
  // everything in flight has been answered.
  assign dec_stall = (outst == outst_t'(MAX_OUTST)) | (busy & (dec != sel_q)) | drain;

  always_comb begin
    slv_stall = 1'b0;
    rsp_ack   = 1'b0;
    rsp_err   = 1'b0;
    rsp_dat   = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (dec == sel_t'(i)) slv_stall = s_stall[i];
      if (sel_q == sel_t'(i)) begin
        rsp_ack = s_ack[i];
        rsp_err = s_err[i];
        rsp_dat = s_rdat[i];
      end
    end
  end

  assign accept = m.cyc & m.stb & ~dec_stall & ~slv_stall;
  // An unmapped request is answered by uerr_q one cycle after its accept.
  assign rsp    = busy & (uerr_q | ((rsp_ack | rsp_err) & ~drain));

  // Bus outputs are forced quiet while reset is held, whatever the master drives.
  always_comb begin
    s_cyc = '0;
    s_stb = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      s_stb[i] = ~rst & m.stb & ~dec_stall & (dec == sel_t'(i));
      s_cyc[i] = ~rst & m.cyc & (((dec == sel_t'(i)) & m.stb) | ((sel_q == sel_t'(i)) & busy));
    end
  end

  for (genvar g = 0; g < int'(NSLV); g++) begin : g_slv
    assign s[g].cyc   = s_cyc[g];
    assign s[g].stb   = s_stb[g];
    assign s[g].we    = m.we;
    assign s[g].adr   = m.adr;
    assign s[g].sel   = m.sel;
    assign s[g].dat_i = m.dat_i;
    assign s_ack[g]   = s[g].ack;
    assign s_err[g]   = s[g].err;
    assign s_stall[g] = s[g].stall;
    assign s_rdat[g]  = s[g].dat_o;
  end

  assign m.ack   = ~rst & rsp_ack & ~drain;
  assign m.err   = ~rst & ((rsp_err & ~drain) | uerr_q | tmo_fire);
  assign m.stall = ~rst & (dec_stall | slv_stall);
  assign m.dat_o = rsp_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= '0;
      outst  <= '0;
      uerr_q <= 1'b0;
      drain  <= 1'b0;
    end else begin
      if (accept) sel_q <= dec;
      if (!m.cyc) begin
        outst  <= '0;
        uerr_q <= 1'b0;
        drain  <= 1'b0;
      end else begin
        uerr_q <= accept & (dec == UNMAPPED);
        if (tmo_fire) begin
          outst <= '0;
          drain <= 1'b1;
        end else begin
          outst <= outst + outst_t'(accept) - outst_t'(rsp);
        end
      end
    end
  end

  assign tmo_en = m.cyc & busy;

  wb_decoder_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk  (clk),
    .rst  (rst),
    .clr  (rsp | ~tmo_en),
    .en   (tmo_en),
    .fire (tmo_fire)
  );
endmodule

// File: tb/tb_wb_decoder.sv
// tb/tb_wb_decoder.sv - self-checking bench for wb_decoder with behavioural slaves and scoreboard
module tb_wb_decoder;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;
  int   kcyc   = 0;

  int       lat [4];
  logic [3:0] noack, late, stall_cfg;
  logic [3:0] s_stb_w, s_cyc_w;

  always #5 clk = ~clk;
  always @(posedge clk) kcyc <= kcyc + 1;

  wb_if m_if (.clk(clk));
  wb_if s_if [4] (.clk(clk));

  wb_decoder dut (.clk(clk), .rst(rst), .m(m_if), .s(s_if));

  function automatic logic [31:0] rd_data(input logic [31:0] a, input int i);
    return a ^ (32'h1111_1111 * 32'(i + 1));
  endfunction

  // Address map written as plain ranges; 4 means no slave.
  function automatic int tgt_of(input logic [31:0] a);
    if (a < 32'h0001_0000) return 0;
    if (a >= 32'h1000_0000 && a < 32'h1000_1000) return 1;
    if (a >= 32'h2000_0000 && a < 32'h2000_1000) return 2;
    if (a >= 32'h3000_0000 && a < 32'h3000_1000) return 3;
    return 4;
  endfunction

  // Behavioural slaves: in-order queue of {due cycle, data}, ack once due.
  for (genvar g = 0; g < 4; g++) begin : g_slv
    logic [63:0] q[$];
    logic [63:0] tmp;
    logic        ack_q;
    logic [31:0] dat_q;
    assign s_if[g].ack   = ack_q | late[g];
    assign s_if[g].err   = 1'b0;
    assign s_if[g].stall = stall_cfg[g];
    assign s_if[g].dat_o = dat_q;
    assign s_stb_w[g]    = s_if[g].stb;
    assign s_cyc_w[g]    = s_if[g].cyc;
    initial begin
      ack_q = 1'b0;
      dat_q = '0;
      forever begin
        @(negedge clk);
        if (rst || !s_if[g].cyc) begin
          q.delete();
        end else begin
          if (s_if[g].ack && q.size() > 0) tmp = q.pop_front();
          if (s_if[g].stb && !s_if[g].stall)
            q.push_back({32'(kcyc + lat[g]), rd_data(s_if[g].adr, g)});
        end
        @(posedge clk); #1;
        if (q.size() > 0 && !noack[g] && int'(q[0][63:32]) <= kcyc) begin
          ack_q = 1'b1;
          dat_q = q[0][31:0];
        end else begin
          ack_q = 1'b0;
          dat_q = '0;
        end
      end
    end
  end

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
    logic [31:0] acc;
  } exp_t;

  // Drives a request list with one master cycle; checks stalls against an
  // in-order outstanding-count model and every response against a scoreboard.
  task automatic run_stream(input string name, input logic [31:0] addrs[$], input int gap_pct);
    exp_t eq[$];
    exp_t e;
    int   infl = 0, last_t = 0, idx = 0, budget = 0, t;
    logic e_stall, acc, rsp;
    logic [3:0] em;
    m_if.cyc = 1'b1;
    m_if.we  = 1'b0;
    while ((idx < addrs.size() || eq.size() > 0) && budget < 2000) begin
      if (idx < addrs.size() && !(gap_pct > 0 && int'($urandom_range(99)) < gap_pct)) begin
        m_if.stb = 1'b1;
        m_if.adr = addrs[idx];
      end else begin
        m_if.stb = 1'b0;
      end
      @(negedge clk);
      t = tgt_of(m_if.adr);
      e_stall = (infl == 4) || (infl > 0 && t != last_t);
      if (m_if.stb) begin
        checks++;
        if (m_if.stall !== e_stall)
          $display("FAIL %s stall adr=%h got %b want %b", name, m_if.adr, m_if.stall, e_stall);
        else passed++;
      end
      acc = m_if.stb && !m_if.stall;
      if (acc) begin
        em = (t < 4) ? 4'(1 << t) : 4'b0;
        checks++;
        if (s_stb_w !== em)
          $display("FAIL %s route adr=%h got %b want %b", name, m_if.adr, s_stb_w, em);
        else passed++;
        eq.push_back('{err: (t == 4), dat: (t == 4) ? 32'h0 : rd_data(m_if.adr, t), acc: 32'(kcyc)});
        last_t = t;
        idx++;
      end
      rsp = m_if.ack || m_if.err;
      if (rsp) begin
        checks++;
        if (eq.size() == 0) begin
          $display("FAIL %s unexpected response ack=%b err=%b want none", name, m_if.ack, m_if.err);
        end else begin
          e = eq.pop_front();
          if (e.err && ({m_if.ack, m_if.err} !== 2'b01 || 32'(kcyc) != e.acc + 1))
            $display("FAIL %s err response ack=%b err=%b cyc=%0d want err at %0d",
                     name, m_if.ack, m_if.err, kcyc, e.acc + 1);
          else if (!e.err && ({m_if.ack, m_if.err} !== 2'b10 || m_if.dat_o !== e.dat))
            $display("FAIL %s ack response ack=%b err=%b dat=%h want ack dat=%h",
                     name, m_if.ack, m_if.err, m_if.dat_o, e.dat);
          else passed++;
        end
      end
      infl = infl + int'(acc) - int'(rsp);
      @(posedge clk); #1;
      budget++;
    end
    checks++;
    if (budget >= 2000) $display("FAIL %s cycle budget expired left=%0d want 0", name, eq.size());
    else passed++;
    m_if.stb = 1'b0;
    m_if.cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({m_if.ack, m_if.err, m_if.stall} !== 3'b000)
      $display("FAIL reset m ack/err/stall got %b want 000", {m_if.ack, m_if.err, m_if.stall}); else passed++;
    checks++; if ({s_cyc_w, s_stb_w} !== 8'h00)
      $display("FAIL reset s cyc/stb got %h want 00", {s_cyc_w, s_stb_w}); else passed++;
    checks++; if (dut.outst !== '0)
      $display("FAIL reset outst got %0d want 0", dut.outst); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_led_write();
    lat[1] = 1;
    m_if.cyc = 1'b1; m_if.stb = 1'b1; m_if.we = 1'b1;
    m_if.adr = 32'h1000_0000; m_if.dat_i = 32'h5;
    @(negedge clk);
    checks++; if (s_stb_w !== 4'b0010 || s_cyc_w !== 4'b0010 || m_if.stall !== 1'b0)
      $display("FAIL led stb got stb=%b cyc=%b stall=%b want 0010 0010 0", s_stb_w, s_cyc_w, m_if.stall);
    else passed++;
    checks++; if (s_if[1].we !== 1'b1 || s_if[1].dat_i !== 32'h5)
      $display("FAIL led we/dat got %b %h want 1 00000005", s_if[1].we, s_if[1].dat_i); else passed++;
    @(posedge clk); #1;
    m_if.stb = 1'b0; m_if.we = 1'b0;
    @(negedge clk);
    checks++; if (m_if.ack !== 1'b1 || m_if.err !== 1'b0)
      $display("FAIL led ack got ack=%b err=%b want 1 0", m_if.ack, m_if.err); else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (m_if.ack !== 1'b0)
      $display("FAIL led single ack got %b want 0", m_if.ack); else passed++;
    @(posedge clk); #1;
    m_if.cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_burst();
    logic [31:0] a[$];
    lat[0] = 5;
    for (int i = 0; i < 5; i++) a.push_back(32'h10 + 32'(4 * i));
    run_stream("burst", a, 0);
  endtask

  task automatic test_switch();
    logic [31:0] a[$];
    lat[1] = 1; lat[0] = 2;
    a.push_back(32'h1000_0000);
    a.push_back(32'h0000_0000);
    run_stream("switch", a, 0);
  endtask

  task automatic test_unmapped();
    logic [31:0] a[$];
    a.push_back(32'h7000_0000);
    a.push_back(32'h7000_0004);
    run_stream("unmapped", a, 0);
    checks++; if (dut.outst !== '0)
      $display("FAIL unmapped outst got %0d want 0", dut.outst); else passed++;
  endtask

  task automatic test_boundaries();
    logic [31:0] a[$];
    a.push_back(32'h0000_FFFC); a.push_back(32'h0001_0000);
    a.push_back(32'h1000_0FFC); a.push_back(32'h1000_1000);
    a.push_back(32'h2000_0FFC); a.push_back(32'h3000_0FFC);
    a.push_back(32'h3000_1000); a.push_back(32'hFFFF_FFFC);
    run_stream("boundary", a, 0);
  endtask

  task automatic test_slave_stall();
    int n;
    lat[3] = 2; stall_cfg[3] = 1'b1;
    m_if.cyc = 1'b1; m_if.stb = 1'b1; m_if.we = 1'b0; m_if.adr = 32'h3000_0040;
    @(negedge clk);
    checks++; if (m_if.stall !== 1'b1 || s_stb_w !== 4'b1000)
      $display("FAIL slvstall held got stall=%b stb=%b want 1 1000", m_if.stall, s_stb_w); else passed++;
    @(posedge clk); #1;
    stall_cfg[3] = 1'b0;
    @(negedge clk);
    checks++; if (m_if.stall !== 1'b0)
      $display("FAIL slvstall release got %b want 0", m_if.stall); else passed++;
    @(posedge clk); #1;
    m_if.stb = 1'b0;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (m_if.ack === 1'b1) break;
      @(posedge clk); #1;
    end
    checks++; if (n >= 10 || m_if.dat_o !== rd_data(32'h3000_0040, 3))
      $display("FAIL slvstall ack n=%0d dat=%h want ack dat=%h", n, m_if.dat_o, rd_data(32'h3000_0040, 3));
    else passed++;
    @(posedge clk); #1;
    m_if.cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] a[$];
    logic [31:0] bases[5] = '{32'h0, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h7000_0000};
    for (int i = 0; i < 4; i++) lat[i] = int'($urandom_range(1, 4));
    for (int i = 0; i < 60; i++)
      a.push_back(bases[$urandom_range(4)] + (32'($urandom_range(1023)) << 2));
    run_stream("random", a, 20);
  endtask

  task automatic test_timeout();
    int  n;
    logic seen;
    logic [31:0] a[$];
    noack[2] = 1'b1; lat[2] = 1;
    m_if.cyc = 1'b1; m_if.stb = 1'b1; m_if.we = 1'b0; m_if.adr = 32'h2000_0000;
    @(negedge clk);
    checks++; if (m_if.stall !== 1'b0 || s_stb_w !== 4'b0100)
      $display("FAIL tmo accept got stall=%b stb=%b want 0 0100", m_if.stall, s_stb_w); else passed++;
    @(posedge clk); #1;
    m_if.stb = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 1100) begin
      @(negedge clk);
      n++;
      if (m_if.err === 1'b1) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++; if (!seen || n != 1024)
      $display("FAIL tmo latency got %0d seen=%b want 1024", n, seen); else passed++;
    @(posedge clk); #1;
    late[2] = 1'b1; m_if.stb = 1'b1; m_if.adr = 32'h0000_0000;
    @(negedge clk);
    checks++; if ({m_if.ack, m_if.err} !== 2'b00)
      $display("FAIL tmo late ack got ack=%b err=%b want 0 0", m_if.ack, m_if.err); else passed++;
    checks++; if (m_if.stall !== 1'b1 || s_stb_w !== 4'b0000)
      $display("FAIL tmo drain got stall=%b stb=%b want 1 0000", m_if.stall, s_stb_w); else passed++;
    @(posedge clk); #1;
    late[2] = 1'b0; noack[2] = 1'b0; m_if.stb = 1'b0; m_if.cyc = 1'b0;
    @(posedge clk); #1;
    a.push_back(32'h2000_0004);
    run_stream("tmo_recover", a, 0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] a[$];
    lat[0] = 10;
    m_if.cyc = 1'b1; m_if.we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_if.stb = 1'b1; m_if.adr = 32'(4 * i);
      @(negedge clk);
      checks++; if (m_if.stall !== 1'b0)
        $display("FAIL rstmid accept %0d stall got %b want 0", i, m_if.stall); else passed++;
      @(posedge clk); #1;
    end
    m_if.adr = 32'hC;
    #1 rst = 1'b1;
    #1;
    checks++; if ({s_cyc_w, s_stb_w} !== 8'h00)
      $display("FAIL rstmid s cyc/stb got %h want 00", {s_cyc_w, s_stb_w}); else passed++;
    checks++; if ({m_if.ack, m_if.err, m_if.stall} !== 3'b000)
      $display("FAIL rstmid m ack/err/stall got %b want 000", {m_if.ack, m_if.err, m_if.stall}); else passed++;
    m_if.stb = 1'b0; m_if.cyc = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (dut.outst !== '0)
      $display("FAIL rstmid outst got %0d want 0", dut.outst); else passed++;
    @(posedge clk); #1;
    lat[3] = 3;
    for (int i = 0; i < 4; i++) a.push_back(32'h3000_0100 + 32'(4 * i));
    run_stream("post_reset", a, 0);
  endtask

  initial begin
    rst = 1'b1;
    m_if.cyc = 1'b0; m_if.stb = 1'b0; m_if.we = 1'b0;
    m_if.adr = '0; m_if.dat_i = '0; m_if.sel = 4'hF;
    for (int i = 0; i < 4; i++) lat[i] = 1;
    noack = '0; late = '0; stall_cfg = '0;
    test_reset();
    test_led_write();
    test_burst();
    test_switch();
    test_unmapped();
    test_boundaries();
    test_slave_stall();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
